// File: rtl/sobel_calc_pipe_if.sv
// Window-in / pixel-out handshake bundle for sobel_calc_pipe.
// thresh_i exists only when SOBEL_THRESHOLD_EN is defined.
interface sobel_calc_pipe_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] d0_i;
   logic [DATA_W-1:0] d1_i;
   logic [DATA_W-1:0] d2_i;
   logic [DATA_W-1:0] d3_i;
   logic [DATA_W-1:0] d4_i;
   logic [DATA_W-1:0] d5_i;
   logic [DATA_W-1:0] d6_i;
   logic [DATA_W-1:0] d7_i;
   logic [DATA_W-1:0] d8_i;
   logic              done_i;
   logic              ready_o;
   logic [1:0]        mode_i;
   logic              ready_i;
   logic [DATA_W-1:0] grayscale_o;
   logic              done_o;
`ifdef SOBEL_THRESHOLD_EN
   logic [DATA_W-1:0] thresh_i;

   modport master (
      output d0_i, d1_i, d2_i,
      output d3_i, d4_i, d5_i,
      output d6_i, d7_i, d8_i,
      output done_i, mode_i,
      output ready_i, thresh_i,
      input  ready_o,
      input  grayscale_o, done_o
   );

   modport slave (
      input  d0_i, d1_i, d2_i,
      input  d3_i, d4_i, d5_i,
      input  d6_i, d7_i, d8_i,
      input  done_i, mode_i,
      input  ready_i, thresh_i,
      output ready_o,
      output grayscale_o, done_o
   );
`else
   modport master (
      output d0_i, d1_i, d2_i,
      output d3_i, d4_i, d5_i,
      output d6_i, d7_i, d8_i,
      output done_i, mode_i,
      output ready_i,
      input  ready_o,
      input  grayscale_o, done_o
   );

   modport slave (
      input  d0_i, d1_i, d2_i,
      input  d3_i, d4_i, d5_i,
      input  d6_i, d7_i, d8_i,
      input  done_i, mode_i,
      input  ready_i,
      output ready_o,
      output grayscale_o, done_o
   );
`endif
endinterface

// File: rtl/sobel_calc_pipe.sv
// 3-stage pipelined Sobel magnitude with mode select, shift, saturation.
// Define SOBEL_THRESHOLD_EN to turn the output into a binary edge map.
module sobel_calc_pipe #(
   parameter int DATA_W = 8,
   parameter int SHIFT  = 0
) (
   input  logic             clk,
   input  logic             rst,
   sobel_calc_pipe_if.slave bus
);
   localparam int PW = DATA_W + 2;
   localparam int SW = DATA_W + 3;
   localparam logic [SW-1:0] MAXV =
      {{3{1'b0}}, {DATA_W{1'b1}}};

   typedef struct packed {
      logic [PW-1:0] px;
      logic [PW-1:0] nx;
      logic [PW-1:0] py;
      logic [PW-1:0] ny;
      logic [1:0]    mode;
   } s1_t;

   typedef struct packed {
      logic [PW-1:0] ax;
      logic [PW-1:0] ay;
      logic [1:0]    mode;
   } s2_t;

   function automatic logic [PW-1:0] wsum(
      input logic [DATA_W-1:0] a,
      input logic [DATA_W-1:0] b,
      input logic [DATA_W-1:0] c
   );
      return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
   endfunction

   function automatic logic [PW-1:0] adiff(
      input logic [PW-1:0] p,
      input logic [PW-1:0] n
   );
      logic [SW-1:0] d;
      d = {1'b0, p} - {1'b0, n};
      if (d[SW-1])
         d = -d;
      return d[PW-1:0];
   endfunction

   logic              v1;
   logic              v2;
   logic              v3;
   logic              en;
   s1_t               s1_q;
   s1_t               s1_d;
   s2_t               s2_q;
   s2_t               s2_d;
   logic [SW-1:0]     m;
   logic [SW-1:0]     s;
   logic [DATA_W-1:0] sat;
   logic [DATA_W-1:0] res;
   logic [DATA_W-1:0] gray_q;

   // Whole pipe stalls together; bubbles are never collapsed.
   assign en = bus.ready_i | ~v3;

   always_comb begin
      s1_d      = '0;
      s1_d.px   = wsum(bus.d2_i, bus.d5_i, bus.d8_i);
      s1_d.nx   = wsum(bus.d0_i, bus.d3_i, bus.d6_i);
      s1_d.py   = wsum(bus.d6_i, bus.d7_i, bus.d8_i);
      s1_d.ny   = wsum(bus.d0_i, bus.d1_i, bus.d2_i);
      s1_d.mode = bus.mode_i;
   end

   always_comb begin
      s2_d      = '0;
      s2_d.ax   = adiff(s1_q.px, s1_q.nx);
      s2_d.ay   = adiff(s1_q.py, s1_q.ny);
      s2_d.mode = s1_q.mode;
   end

   always_comb begin
      m = '0;
      unique case (1'b1)
         (s2_q.mode == 2'd0):
            m = {1'b0, s2_q.ax} + {1'b0, s2_q.ay};
         (s2_q.mode == 2'd1):
            m = {1'b0, s2_q.ax};
         (s2_q.mode == 2'd2):
            m = {1'b0, s2_q.ay};
         default:
            m = (s2_q.ax >= s2_q.ay) ?
                {1'b0, s2_q.ax} : {1'b0, s2_q.ay};
      endcase
      s   = m >> SHIFT;
      sat = (s > MAXV) ? '1 : s[DATA_W-1:0];
`ifdef SOBEL_THRESHOLD_EN
      res = (sat >= bus.thresh_i) ? '1 : '0;
`else
      res = sat;
`endif
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1     <= 1'b0;
         v2     <= 1'b0;
         v3     <= 1'b0;
         s1_q   <= '0;
         s2_q   <= '0;
         gray_q <= '0;
      end else if (en) begin
         v1     <= bus.done_i;
         v2     <= v1;
         v3     <= v2;
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         gray_q <= res;
      end
   end

   assign bus.ready_o     = en;
   assign bus.done_o      = v3;
   assign bus.grayscale_o = gray_q;

endmodule

// File: tb/tb_sobel_calc_pipe.sv
// Directed bench for sobel_calc_pipe: SHIFT=0 and SHIFT=2 instances
// run in lockstep from the same stimulus.
module tb_sobel_calc_pipe;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sobel_calc_pipe_if #(.DATA_W(DW)) bus_a ();
   sobel_calc_pipe_if #(.DATA_W(DW)) bus_b ();

   sobel_calc_pipe #(.DATA_W(DW), .SHIFT(0)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_a)
   );

   sobel_calc_pipe #(.DATA_W(DW), .SHIFT(2)) u_s2 (
      .clk (clk),
      .rst (rst),
      .bus (bus_b)
   );

   assign bus_b.d0_i    = bus_a.d0_i;
   assign bus_b.d1_i    = bus_a.d1_i;
   assign bus_b.d2_i    = bus_a.d2_i;
   assign bus_b.d3_i    = bus_a.d3_i;
   assign bus_b.d4_i    = bus_a.d4_i;
   assign bus_b.d5_i    = bus_a.d5_i;
   assign bus_b.d6_i    = bus_a.d6_i;
   assign bus_b.d7_i    = bus_a.d7_i;
   assign bus_b.d8_i    = bus_a.d8_i;
   assign bus_b.done_i  = bus_a.done_i;
   assign bus_b.mode_i  = bus_a.mode_i;
   assign bus_b.ready_i = bus_a.ready_i;
`ifdef SOBEL_THRESHOLD_EN
   assign bus_b.thresh_i = bus_a.thresh_i;
`endif

   function automatic int fin(input int v);
`ifdef SOBEL_THRESHOLD_EN
      return (v >= 30) ? 255 : 0;
`else
      return v;
`endif
   endfunction

   task automatic chk(
      input string       tag,
      input logic [31:0] obs,
      input logic [31:0] exp
   );
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d",
                tag, obs, exp);
      end
   endtask

   task automatic drive(
      input logic [8:0][DW-1:0] w,
      input logic [1:0]         md,
      input logic               dv
   );
      bus_a.d0_i   = w[0];
      bus_a.d1_i   = w[1];
      bus_a.d2_i   = w[2];
      bus_a.d3_i   = w[3];
      bus_a.d4_i   = w[4];
      bus_a.d5_i   = w[5];
      bus_a.d6_i   = w[6];
      bus_a.d7_i   = w[7];
      bus_a.d8_i   = w[8];
      bus_a.mode_i = md;
      bus_a.done_i = dv;
   endtask

   // Right column k, rest 0: |Gx|=4k, |Gy|=0.
   function automatic logic [8:0][DW-1:0] kwin(input int k);
      logic [8:0][DW-1:0] w;
      w    = '0;
      w[2] = DW'(k);
      w[5] = DW'(k);
      w[8] = DW'(k);
      return w;
   endfunction

   task automatic one(
      input string              tag,
      input logic [8:0][DW-1:0] w,
      input logic [1:0]         md,
      input int                 exp_a,
      input int                 exp_b
   );
      int n;
      @(negedge clk);
      drive(w, md, 1'b1);
      #1;
      chk({tag, "_rdy"}, 32'(bus_a.ready_o), 1);
      @(negedge clk);
      bus_a.done_i = 1'b0;
      n = 1;
      while (bus_a.done_o !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_lat"}, n, 3);
      chk({tag, "_a"}, 32'(bus_a.grayscale_o), exp_a);
      chk({tag, "_b"}, 32'(bus_b.grayscale_o), exp_b);
   endtask

   task automatic stream(
      input string tag,
      input int    st_at,
      input int    st_len
   );
      int         wi;
      int         oi;
      int         cyc;
      int         hi;
      int         first;
      int         last;
      logic [7:0] held;
      logic       hv;
      wi    = 0;
      oi    = 0;
      cyc   = 0;
      hi    = 0;
      first = -1;
      last  = -1;
      held  = '0;
      hv    = 1'b0;
      while (oi < 10 && cyc < 100) begin
         @(negedge clk);
         bus_a.ready_i = !(cyc >= st_at &&
                           cyc < st_at + st_len);
         if (wi < 10)
            drive(kwin(wi + 1), 2'd0, 1'b1);
         else
            bus_a.done_i = 1'b0;
         #1;
         if (bus_a.done_o) begin
            hi++;
            if (first < 0)
               first = cyc;
            last = cyc;
         end
         if (bus_a.done_o && !bus_a.ready_i) begin
            chk({tag, "_stall_rdy"},
                32'(bus_a.ready_o), 0);
            if (hv)
               chk({tag, "_held"},
                   32'(bus_a.grayscale_o), 32'(held));
            held = bus_a.grayscale_o;
            hv   = 1'b1;
         end else begin
            hv = 1'b0;
         end
         if (bus_a.done_o && bus_a.ready_i) begin
            chk({tag, "_a"}, 32'(bus_a.grayscale_o),
                fin(4 * (oi + 1)));
            chk({tag, "_b"}, 32'(bus_b.grayscale_o),
                fin(oi + 1));
            oi++;
         end
         if (bus_a.done_i && bus_a.ready_o)
            wi++;
         cyc++;
      end
      bus_a.done_i  = 1'b0;
      bus_a.ready_i = 1'b1;
      chk({tag, "_outs"}, oi, 10);
      chk({tag, "_ins"}, wi, 10);
      chk({tag, "_first"}, first, 3);
      chk({tag, "_hi"}, hi, 10 + st_len);
      chk({tag, "_span"}, last - first + 1, 10 + st_len);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      logic [8:0][DW-1:0] w19;
      logic [8:0][DW-1:0] w91;
      logic [8:0][DW-1:0] wedge;
      logic [8:0][DW-1:0] wuni;
      logic [8:0][DW-1:0] wbnd;
      w19   = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5,
               8'd4, 8'd3, 8'd2, 8'd1};
      w91   = {8'd1, 8'd2, 8'd3, 8'd4, 8'd5,
               8'd6, 8'd7, 8'd8, 8'd9};
      wedge = {8'd255, 8'd0, 8'd0, 8'd255, 8'd0,
               8'd0, 8'd255, 8'd0, 8'd0};
      wuni  = {9{8'd100}};
      wbnd  = {8'd65, 8'd0, 8'd0, 8'd63, 8'd0,
               8'd0, 8'd64, 8'd0, 8'd0};

      bus_a.ready_i = 1'b1;
      drive('0, 2'd0, 1'b0);
`ifdef SOBEL_THRESHOLD_EN
      bus_a.thresh_i = 8'd30;
`endif

      #12;
      chk("rst_done", 32'(bus_a.done_o), 0);
      chk("rst_gray", 32'(bus_a.grayscale_o), 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_rdy", 32'(bus_a.ready_o), 1);

      one("m0", w19, 2'd0, fin(32), fin(8));
      one("m1", w19, 2'd1, fin(8),  fin(2));
      one("m2", w19, 2'd2, fin(24), fin(6));
      one("m3", w19, 2'd3, fin(24), fin(6));
      one("neg", w91, 2'd0, fin(32), fin(8));
      one("edge0", wedge, 2'd0, fin(255), fin(255));
      one("edge1", wedge, 2'd1, fin(255), fin(255));
      one("edge2", wedge, 2'd2, fin(0), fin(0));
      one("uni", wuni, 2'd0, fin(0), fin(0));
      one("bnd1", wbnd, 2'd1, fin(255), fin(63));
      one("bnd0", wbnd, 2'd0, fin(255), fin(64));

      stream("burst", 1000, 0);
      stream("stall", 5, 4);

      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         drive(kwin(k), 2'd0, 1'b1);
      end
      @(posedge clk);
      #1;
      bus_a.done_i = 1'b0;
      chk("fly_done", 32'(bus_a.done_o), 1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_done", 32'(bus_a.done_o), 0);
      chk("arst_gray", 32'(bus_a.grayscale_o), 0);
      chk("arst_gray_b", 32'(bus_b.grayscale_o), 0);
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("stale", 32'(bus_a.done_o), 0);
      end
      one("post", w19, 2'd0, fin(32), fin(8));

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
